// File: rtl/seq_shift_unit.sv
// Multi-cycle SRL/SLL/SRA shifter for the RV32 execute stage. It accepts one request, shifts up to
// STEP bits per cycle, and returns the result over a valid/ready handshake.
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [SHAMT_W-1:0] req_shamt,
    input  logic [1:0]         req_type,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);
    localparam logic [1:0] OP_SRL  = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               req_ready_q, busy_q, resp_valid_q;

    logic [SHAMT_W-1:0] k_s;
    logic [SHAMT_W-1:0] cnt_nx_s;
    logic [WIDTH-1:0]   fill_mask_s;
    logic [WIDTH-1:0]   shifted_s;

    // One shift step: amount is clipped to the bits still owed, so the counter never underflows.
    always_comb begin
        k_s         = (cnt_q >= STEP_C) ? STEP_C : cnt_q;
        cnt_nx_s    = cnt_q - k_s;
        fill_mask_s = ~({WIDTH{1'b1}} >> k_s);
        case (op_q)
            OP_SRL:  shifted_s = r_q >> k_s;
            OP_SLL:  shifted_s = r_q << k_s;
            OP_SRA:  shifted_s = (r_q >> k_s) | (sign_q ? fill_mask_s : {WIDTH{1'b0}});
            default: shifted_s = r_q;
        endcase
    end

    // Next-state logic; resp_data is only ever reloaded on the transition into DONE.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sign_d  = sign_q;
        data_d  = data_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = {SHAMT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_d    = req_a;
                        cnt_d  = req_shamt;
                        op_d   = req_type;
                        sign_d = req_a[WIDTH-1];
                        if ((req_type == OP_PASS) || (req_shamt == {SHAMT_W{1'b0}})) begin
                            state_d = ST_DONE;
                            data_d  = req_a;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_d   = shifted_s;
                    cnt_d = cnt_nx_s;
                    if (cnt_nx_s == {SHAMT_W{1'b0}}) begin
                        state_d = ST_DONE;
                        data_d  = shifted_s;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {SHAMT_W{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            r_q          <= {WIDTH{1'b0}};
            cnt_q        <= {SHAMT_W{1'b0}};
            op_q         <= 2'b00;
            sign_q       <= 1'b0;
            data_q       <= {WIDTH{1'b0}};
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            sign_q       <= sign_d;
            data_q       <= data_d;
            req_ready_q  <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            resp_valid_q <= (state_d == ST_DONE);
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = data_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: two instances (STEP=1 and STEP=4) run against a cycle-count/arithmetic
// reference model, with directed scenarios followed by randomized traffic.
module tb_seq_shift_unit;

    typedef struct {
        int          phase;   // 0 idle, 1 working, 2 result held
        int          left;
        logic [31:0] data;
        logic [31:0] pend;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_a      [2];
    logic [4:0]  req_shamt  [2];
    logic [1:0]  req_type   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_data  [2];
    logic        busy       [2];

    mstate_t m_st [2];
    int      steps [2] = '{1, 4};
    int      n_chk = 0;
    int      n_err = 0;
    logic    cmp_en = 1'b0;

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_a(req_a[0]),
        .req_shamt(req_shamt[0]), .req_type(req_type[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .busy(busy[0])
    );

    seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_a(req_a[1]),
        .req_shamt(req_shamt[1]), .req_type(req_type[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .busy(busy[1])
    );

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                              input logic [1:0] ty);
        logic [31:0] res;
        case (ty)
            2'b00:   res = a >> sh;
            2'b01:   res = a << sh;
            2'b10:   res = $signed(a) >>> sh;
            default: res = a;
        endcase
        return res;
    endfunction

    // Model: result from plain arithmetic, latency = ceil(shamt/STEP) working cycles.
    function automatic mstate_t model_next(input mstate_t s, input logic rst, input logic fl,
                                           input logic rv, input logic [31:0] a,
                                           input logic [4:0] sh, input logic [1:0] ty,
                                           input logic rr, input int step);
        mstate_t n = s;
        int      lat;
        if (!rst) begin
            n.phase = 0;
            n.data  = 32'h0;
        end else if (fl) begin
            n.phase = 0;
        end else if (s.phase == 0) begin
            if (rv) begin
                lat = (ty == 2'b11 || sh == 5'd0) ? 0 : (int'(sh) + step - 1) / step;
                if (lat == 0) begin
                    n.phase = 2;
                    n.data  = ref_shift(a, sh, ty);
                end else begin
                    n.phase = 1;
                    n.left  = lat;
                    n.pend  = ref_shift(a, sh, ty);
                end
            end
        end else if (s.phase == 1) begin
            n.left = s.left - 1;
            if (n.left == 0) begin
                n.phase = 2;
                n.data  = s.pend;
            end
        end else if (rr) begin
            n.phase = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            m_st[l] <= model_next(m_st[l], rst_n, flush[l], req_valid[l], req_a[l],
                                  req_shamt[l], req_type[l], resp_ready[l], steps[l]);
        end
    end

    task automatic chk(input string name, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d: got %h expected %h at %0t", name, lane, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int l = 0; l < 2; l++) begin
                chk("model_req_ready", l, 32'(req_ready[l]), 32'(m_st[l].phase == 0));
                chk("model_busy", l, 32'(busy[l]), 32'(m_st[l].phase != 0));
                chk("model_resp_valid", l, 32'(resp_valid[l]), 32'(m_st[l].phase == 2));
                chk("model_resp_data", l, resp_data[l], m_st[l].data);
            end
        end
    end

    task automatic issue(input int lane, input logic [31:0] a, input logic [4:0] sh,
                         input logic [1:0] ty);
        @(posedge clk); #1;
        req_valid[lane] = 1'b1;
        req_a[lane]     = a;
        req_shamt[lane] = sh;
        req_type[lane]  = ty;
        @(posedge clk); #1;
        req_valid[lane] = 1'b0;
        req_a[lane]     = $urandom;
    endtask

    // Returns the cycle (accept = 0) in which resp_valid is first seen.
    task automatic wait_resp(input int lane, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (resp_valid[lane]) break;
            if (n >= 64) begin
                chk("resp_timeout", lane, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic release_resp(input int lane);
        resp_ready[lane] = 1'b1;
        @(posedge clk); #1;
        resp_ready[lane] = 1'b0;
        @(negedge clk);
        chk("idle_after_release", lane, 32'(req_ready[lane]), 32'd1);
    endtask

    task automatic run_op(input int lane, input logic [31:0] a, input logic [4:0] sh,
                          input logic [1:0] ty, input logic [31:0] exp_d, input int exp_lat);
        int n;
        issue(lane, a, sh, ty);
        wait_resp(lane, n);
        chk("latency", lane, 32'(n), 32'(exp_lat));
        chk("result", lane, resp_data[lane], exp_d);
        release_resp(lane);
    endtask

    initial begin
        int          n;
        logic [31:0] held;
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            flush[l] = 1'b0; req_valid[l] = 1'b0; req_a[l] = 32'h0;
            req_shamt[l] = 5'd0; req_type[l] = 2'b00; resp_ready[l] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("reset_busy", 0, 32'(busy[0]), 32'd0);
        chk("reset_resp_valid", 0, 32'(resp_valid[0]), 32'd0);
        chk("reset_resp_data", 0, resp_data[0], 32'h0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        run_op(0, 32'h0000_0001, 5'd31, 2'b01, 32'h8000_0000, 32);
        run_op(0, 32'h8000_0000, 5'd4, 2'b10, 32'hF800_0000, 5);
        run_op(0, 32'h8000_0000, 5'd4, 2'b00, 32'h0800_0000, 5);
        run_op(1, 32'h8000_0000, 5'd4, 2'b10, 32'hF800_0000, 2);
        run_op(1, 32'h8000_0000, 5'd4, 2'b00, 32'h0800_0000, 2);
        run_op(1, 32'h8765_4321, 5'd31, 2'b10, 32'hFFFF_FFFF, 9);
        run_op(0, 32'h1234_ABCD, 5'd0, 2'b00, 32'h1234_ABCD, 1);
        run_op(0, 32'h1234_ABCD, 5'd7, 2'b11, 32'h1234_ABCD, 1);

        // Backpressure: result must hold and no request may slip in on completion.
        issue(1, 32'h0000_00F0, 5'd8, 2'b01);
        wait_resp(1, n);
        chk("bp_latency", 1, 32'(n), 32'd3);
        held = resp_data[1];
        chk("bp_result", 1, held, 32'h0000_F000);
        req_valid[1] = 1'b1;
        req_a[1] = 32'h5555_5555; req_shamt[1] = 5'd1; req_type[1] = 2'b00;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_hold", 1, 32'(resp_valid[1]), 32'd1);
            chk("bp_data_hold", 1, resp_data[1], 32'h0000_F000);
            chk("bp_req_ready", 1, 32'(req_ready[1]), 32'd0);
        end
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        req_valid[1]  = 1'b0;
        @(negedge clk);
        chk("bp_no_accept_busy", 1, 32'(busy[1]), 32'd0);
        chk("bp_no_accept_ready", 1, 32'(req_ready[1]), 32'd1);

        // Flush in cycle 3 with a competing request.
        issue(0, 32'h0000_0001, 5'd20, 2'b01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush[0] = 1'b1;
        req_valid[0] = 1'b1;
        req_a[0] = 32'hAAAA_0000; req_shamt[0] = 5'd2; req_type[0] = 2'b00;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("flush_busy", 0, 32'(busy[0]), 32'd0);
        chk("flush_resp_valid", 0, 32'(resp_valid[0]), 32'd0);
        chk("flush_keeps_data", 0, resp_data[0], 32'h1234_ABCD);
        @(negedge clk);
        chk("flush_no_accept", 0, 32'(busy[0]), 32'd0);
        run_op(0, 32'h0000_0003, 5'd3, 2'b01, 32'h0000_0018, 4);

        // Reset mid-shift.
        issue(0, 32'hDEAD_BEEF, 5'd16, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
        chk("midrst_resp_valid", 0, 32'(resp_valid[0]), 32'd0);
        chk("midrst_resp_data", 0, resp_data[0], 32'h0);
        run_op(0, 32'hFFFF_0000, 5'd8, 2'b10, 32'hFFFF_FF00, 9);

        // Randomized traffic on both lanes; the compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 299) != 0);
            for (int l = 0; l < 2; l++) begin
                req_valid[l]  = ($urandom_range(0, 1) == 1);
                req_a[l]      = $urandom;
                req_shamt[l]  = 5'($urandom_range(0, 31));
                req_type[l]   = 2'($urandom_range(0, 3));
                resp_ready[l] = ($urandom_range(0, 3) != 0);
                flush[l]      = ($urandom_range(0, 19) == 0);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int l = 0; l < 2; l++) begin
            req_valid[l] = 1'b0; flush[l] = 1'b0; resp_ready[l] = 1'b1;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
